token_manager: RTL and testbench

- Parametrised, sequential successor to the parking token generator.
- Issues a token per parking slot as zero-extended slot number XOR a rolling pattern. The pattern advances after every successful issue, so tokens for the same slot change on each visit.
- Stores issued tokens in a per-slot table with occupancy flags, and verifies tokens presented at exit.
- Sits between the entry/exit gate controllers and the slot-occupancy logic.

---
 rtl/token_manager.sv | 129 ++++++++++++
 tb/tb_token_manager.sv | 136 +++++++++++++
 2 files changed

// File: rtl/token_manager.sv
// token_manager: issues per-slot parking tokens from a rolling pattern, tracks occupancy, verifies exit tokens.
module token_manager #(
  parameter int SLOT_W = 3,
  parameter int TOKEN_W = 3,
  parameter int NUM_SLOTS = 8,
  parameter logic [TOKEN_W-1:0] SEED = 'b101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_req,
  input  logic [SLOT_W-1:0]    issue_slot,
  input  logic                 verify_req,
  input  logic [SLOT_W-1:0]    verify_slot,
  input  logic [TOKEN_W-1:0]   verify_token,
  output logic                 busy,
  output logic                 token_valid,
  output logic [TOKEN_W-1:0]   token_out,
  output logic                 verify_done,
  output logic                 verify_ok,
  output logic                 error,
  output logic [NUM_SLOTS-1:0] occupied
);
  localparam int DEPTH = 2 ** SLOT_W;
  localparam logic [TOKEN_W-1:0] SEED_EFF = (SEED == '0) ? TOKEN_W'(1) : SEED;
  localparam logic [SLOT_W:0] NS = NUM_SLOTS[SLOT_W:0];
  typedef enum logic [1:0] {IDLE, ISSUE, VERIFY, RESP} state_t;
  state_t state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [TOKEN_W-1:0] vtok_q, vtok_d, pat_q, pat_d, tok_q, tok_d, new_tok;
  logic [TOKEN_W-1:0] tbl_q [DEPTH];
  logic [TOKEN_W-1:0] tbl_d [DEPTH];
  logic [DEPTH-1:0] occ_q, occ_d;
  logic ptv_q, ptv_d, pvd_q, pvd_d, pok_q, pok_d, perr_q, perr_d;
  logic tv_q, tv_d, vd_q, vd_d, ok_q, ok_d, err_q, err_d;
  logic in_range;
  assign in_range = {1'b0, slot_q} < NS;
  assign new_tok = TOKEN_W'(slot_q) ^ pat_q;
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    vtok_d = vtok_q;
    pat_d = pat_q;
    tok_d = tok_q;
    tbl_d = tbl_q;
    occ_d = occ_q;
    ptv_d = 1'b0;
    pvd_d = 1'b0;
    pok_d = 1'b0;
    perr_d = 1'b0;
    tv_d = 1'b0;
    vd_d = 1'b0;
    err_d = 1'b0;
    ok_d = ok_q;
    case (state_q)
      IDLE: begin
        if (issue_req) begin
          slot_d = issue_slot;
          state_d = ISSUE;
        end else if (verify_req) begin
          slot_d = verify_slot;
          vtok_d = verify_token;
          state_d = VERIFY;
        end
      end
      ISSUE: begin
        state_d = RESP;
        if (in_range && !occ_q[slot_q]) begin
          tbl_d[slot_q] = new_tok;
          occ_d[slot_q] = 1'b1;
          tok_d = new_tok;
          pat_d = {pat_q[TOKEN_W-2:0], pat_q[TOKEN_W-1] ^ pat_q[TOKEN_W-2]};
          ptv_d = 1'b1;
        end else begin
          perr_d = 1'b1;
        end
      end
      VERIFY: begin
        state_d = RESP;
        pvd_d = 1'b1;
        if (in_range && occ_q[slot_q]) begin
          if (tbl_q[slot_q] == vtok_q) begin
            occ_d[slot_q] = 1'b0;
            pok_d = 1'b1;
          end
        end else begin
          perr_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        tv_d = ptv_q;
        vd_d = pvd_q;
        err_d = perr_q;
        ok_d = pvd_q ? pok_q : ok_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q <= '0;
      vtok_q <= '0;
      pat_q <= SEED_EFF;
      tok_q <= '0;
      tbl_q <= '{default: '0};
      occ_q <= '0;
      {ptv_q, pvd_q, pok_q, perr_q} <= '0;
      {tv_q, vd_q, ok_q, err_q} <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      vtok_q <= vtok_d;
      pat_q <= pat_d;
      tok_q <= tok_d;
      tbl_q <= tbl_d;
      occ_q <= occ_d;
      {ptv_q, pvd_q, pok_q, perr_q} <= {ptv_d, pvd_d, pok_d, perr_d};
      {tv_q, vd_q, ok_q, err_q} <= {tv_d, vd_d, ok_d, err_d};
    end
  end
  assign busy = state_q != IDLE;
  assign token_valid = tv_q;
  assign token_out = tok_q;
  assign verify_done = vd_q;
  assign verify_ok = ok_q;
  assign error = err_q;
  assign occupied = occ_q[NUM_SLOTS-1:0];
endmodule

// File: tb/tb_token_manager.sv
// tb_token_manager: directed table-driven bench for token_manager, plus a NUM_SLOTS=6 instance for range checks.
module tb_token_manager;
  logic clk = 1'b0;
  logic rst, issue_req, verify_req;
  logic [2:0] issue_slot, verify_slot, verify_token;
  logic busy, tv, vd, ok, err;
  logic [2:0] tok;
  logic [7:0] occ;
  logic busy1, tv1, vd1, ok1, err1;
  logic [2:0] tok1;
  logic [5:0] occ1;
  int total = 0;
  int bad = 0;

  token_manager dut (
    .clk(clk), .rst(rst), .issue_req(issue_req), .issue_slot(issue_slot),
    .verify_req(verify_req), .verify_slot(verify_slot), .verify_token(verify_token),
    .busy(busy), .token_valid(tv), .token_out(tok), .verify_done(vd),
    .verify_ok(ok), .error(err), .occupied(occ)
  );

  token_manager #(.NUM_SLOTS(6)) dut6 (
    .clk(clk), .rst(rst), .issue_req(issue_req), .issue_slot(issue_slot),
    .verify_req(verify_req), .verify_slot(verify_slot), .verify_token(verify_token),
    .busy(busy1), .token_valid(tv1), .token_out(tok1), .verify_done(vd1),
    .verify_ok(ok1), .error(err1), .occupied(occ1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ireq, vreq;
    logic [2:0] islot, vslot, vtok;
    logic tv;
    logic [2:0] tok;
    logic vd, ok, err;
    logic [7:0] occ;
  } vec_t;

  vec_t v [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t x, input int idx);
    @(negedge clk);
    issue_req = x.ireq; verify_req = x.vreq;
    issue_slot = x.islot; verify_slot = x.vslot; verify_token = x.vtok;
    @(negedge clk);
    issue_req = 1'b0; verify_req = 1'b0;
    chk($sformatf("v%0d busy1", idx), busy, 1);
    @(negedge clk);
    chk($sformatf("v%0d busy2", idx), busy, 1);
    chk($sformatf("v%0d occ", idx), occ, x.occ);
    chk($sformatf("v%0d early_pulse", idx), {tv, vd, err}, 0);
    @(negedge clk);
    chk($sformatf("v%0d busy_end", idx), busy, 0);
    chk($sformatf("v%0d token_valid", idx), tv, x.tv);
    chk($sformatf("v%0d token_out", idx), tok, x.tok);
    chk($sformatf("v%0d verify_done", idx), vd, x.vd);
    chk($sformatf("v%0d verify_ok", idx), ok, x.ok);
    chk($sformatf("v%0d error", idx), err, x.err);
  endtask

  initial begin
    //        ireq vreq islot vslot vtok  tv tok    vd ok err occ
    v[0]  = '{1, 0, 3'd2, 3'd0, 3'b000, 1, 3'b111, 0, 0, 0, 8'b0000_0100};
    v[1]  = '{1, 0, 3'd5, 3'd0, 3'b000, 1, 3'b110, 0, 0, 0, 8'b0010_0100};
    v[2]  = '{0, 1, 3'd0, 3'd2, 3'b111, 0, 3'b110, 1, 1, 0, 8'b0010_0000};
    v[3]  = '{0, 1, 3'd0, 3'd5, 3'b000, 0, 3'b110, 1, 0, 0, 8'b0010_0000};
    v[4]  = '{1, 0, 3'd5, 3'd0, 3'b000, 0, 3'b110, 0, 0, 1, 8'b0010_0000};
    v[5]  = '{1, 0, 3'd0, 3'd0, 3'b000, 1, 3'b111, 0, 0, 0, 8'b0010_0001};
    v[6]  = '{0, 1, 3'd0, 3'd3, 3'b000, 0, 3'b111, 1, 0, 1, 8'b0010_0001};
    v[7]  = '{1, 1, 3'd3, 3'd0, 3'b111, 1, 3'b101, 0, 0, 0, 8'b0010_1001};
    v[8]  = '{0, 1, 3'd0, 3'd0, 3'b111, 0, 3'b101, 1, 1, 0, 8'b0010_1000};
    v[9]  = '{0, 1, 3'd0, 3'd3, 3'b101, 0, 3'b101, 1, 1, 0, 8'b0010_0000};
    v[10] = '{1, 0, 3'd2, 3'd0, 3'b000, 1, 3'b110, 0, 1, 0, 8'b0010_0100};
    v[11] = '{1, 0, 3'd2, 3'd0, 3'b000, 1, 3'b111, 0, 0, 0, 8'b0000_0100};
    rst = 1'b1;
    issue_req = 1'b0; verify_req = 1'b0;
    issue_slot = '0; verify_slot = '0; verify_token = '0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {busy, tv, tok, vd, ok, err}, 0);
    chk("reset occ", occ, 0);
    rst = 1'b0;
    for (int i = 0; i < 11; i++) run(v[i], i);
    // requests held high while busy must be ignored; pattern is 001 here
    @(negedge clk);
    issue_req = 1'b1; issue_slot = 3'd1;
    @(negedge clk);
    issue_slot = 3'd4; verify_req = 1'b1; verify_slot = 3'd5; verify_token = 3'b110;
    @(negedge clk);
    @(negedge clk);
    issue_req = 1'b0; verify_req = 1'b0;
    chk("busy_ign tv", tv, 1);
    chk("busy_ign tok", tok, 3'b000);
    repeat (4) @(negedge clk);
    chk("busy_ign occ", occ, 8'b0010_0110);
    chk("busy_ign idle", busy, 0);
    // slot 7 valid for 8 slots, out of range for 6; pattern is 010
    issue_req = 1'b1; issue_slot = 3'd7;
    @(negedge clk);
    issue_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("slot7 tv", tv, 1);
    chk("slot7 tok", tok, 3'b101);
    chk("slot7 n6 err", err1, 1);
    chk("slot7 n6 tv", tv1, 0);
    chk("slot7 n6 tok", tok1, 3'b000);
    chk("slot7 n6 occ", occ1, 6'b10_0110);
    // reset while in ISSUE drops the request
    @(negedge clk);
    issue_req = 1'b1; issue_slot = 3'd3;
    @(negedge clk);
    issue_req = 1'b0;
    chk("pre_rst busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst outputs", {busy, tv, tok, vd, ok, err}, 0);
    chk("mid_rst occ", occ, 0);
    repeat (2) begin
      @(negedge clk);
      chk("post_rst no pulse", {tv, vd, err}, 0);
    end
    run(v[11], 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
